encode_74ls148_seq: RTL and testbench

- Registered, handshaked 8-to-3 priority encoder in 74LS148 pin style (active-low requests and code); the encode-side counterpart to the 74LS138-style decoder.
- Latches falling-edge requests on I0..I7 into a pending register and presents the highest-priority pending line (I7 highest) as an active-low code.
- Holds each code until it is acknowledged or times out, then clears that request bit.
- Sits between discrete request lines (interrupts or strobes) and a consumer that reads one code at a time.

---
 rtl/encode_74ls148_seq.sv | 116 +++++++++++
 tb/tb_encode_74ls148_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_74ls148_seq.sv
// Registered 8-to-3 priority encoder with 74LS148-style active-low pins.
// Falling request edges queue up in a pending register and are handed out one code at a time.
module encode_74ls148_seq #(
    parameter int unsigned HOLD_TIMEOUT = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    input  logic I5,
    input  logic I6,
    input  logic I7,
    input  logic EI,
    input  logic ACK,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic GS,
    output logic EO,
    output logic OVR,
    output logic TMO
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [15:0] LAST = (HOLD_TIMEOUT == 0) ? 16'd0 : 16'(HOLD_TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  req, prev, pend, pend_next, captured, clear_mask;
    logic [2:0]  code, code_next, sel, a_next;
    logic [15:0] timer, timer_next;
    logic        release_code, timed_out;
    logic        gs_next, eo_next, ovr_next, tmo_next;

    always_comb begin
        req      = {I7, I6, I5, I4, I3, I2, I1, I0};
        captured = EI ? 8'h00 : (prev & ~req);

        sel = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (pend[k]) begin
                sel = 3'(k);
            end
        end

        timed_out    = (HOLD_TIMEOUT != 0) && (timer == LAST) && !ACK;
        release_code = (state == HOLD) && (ACK || timed_out);
        clear_mask   = release_code ? (8'd1 << code) : 8'd0;

        // A fresh edge on the bit being released re-arms it rather than counting as an overrun.
        pend_next = (pend & ~clear_mask) | captured;
        ovr_next  = |(captured & pend & ~clear_mask);
        eo_next   = !(!EI && (pend == 8'h00) && (state == IDLE));

        state_next = state;
        code_next  = code;
        timer_next = timer;
        a_next     = {A2, A1, A0};
        gs_next    = GS;
        tmo_next   = 1'b0;

        case (state)
            IDLE: begin
                if (pend != 8'h00) begin
                    code_next  = sel;
                    a_next     = ~sel;
                    gs_next    = 1'b0;
                    timer_next = 16'd0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (release_code) begin
                    a_next     = 3'b111;
                    gs_next    = 1'b1;
                    tmo_next   = timed_out;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces prev high so lines already low afterwards register as new edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            pend         <= 8'h00;
            prev         <= 8'hFF;
            code         <= 3'd0;
            timer        <= 16'd0;
            {A2, A1, A0} <= 3'b111;
            GS           <= 1'b1;
            EO           <= 1'b1;
            OVR          <= 1'b0;
            TMO          <= 1'b0;
        end else begin
            state        <= state_next;
            pend         <= pend_next;
            prev         <= req;
            code         <= code_next;
            timer        <= timer_next;
            {A2, A1, A0} <= a_next;
            GS           <= gs_next;
            EO           <= eo_next;
            OVR          <= ovr_next;
            TMO          <= tmo_next;
        end
    end

endmodule

// File: tb/tb_encode_74ls148_seq.sv
// Bench for encode_74ls148_seq: two instances (wait-forever and 4-cycle timeout) share stimulus,
// a reference model predicts each cycle and queues expected codes for a GS-edge monitor.
module tb_encode_74ls148_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] lines = 8'hFF;
    logic       EI = 1'b0;
    logic       ACK = 1'b0;

    logic [2:0] a0_n, a4_n;
    logic       gs0, eo0, ovr0, tmo0;
    logic       gs4, eo4, ovr4, tmo4;

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;
    logic gs0_prev = 1'b1;
    logic gs4_prev = 1'b1;

    typedef struct {
        logic [7:0] pend;
        logic [7:0] prev;
        bit         busy;
        int         code;
        int         timer;
        logic [2:0] a;
        logic       gs, eo, ovr, tmo;
    } model_t;

    model_t m0, m4;
    bit     p0, p4;
    int     q0[$];
    int     q4[$];

    encode_74ls148_seq #(.HOLD_TIMEOUT(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .I0(lines[0]), .I1(lines[1]), .I2(lines[2]), .I3(lines[3]),
        .I4(lines[4]), .I5(lines[5]), .I6(lines[6]), .I7(lines[7]),
        .EI(EI), .ACK(ACK),
        .A0(a0_n[0]), .A1(a0_n[1]), .A2(a0_n[2]),
        .GS(gs0), .EO(eo0), .OVR(ovr0), .TMO(tmo0)
    );

    encode_74ls148_seq #(.HOLD_TIMEOUT(4)) dut4 (
        .CLK(CLK), .RST(RST),
        .I0(lines[0]), .I1(lines[1]), .I2(lines[2]), .I3(lines[3]),
        .I4(lines[4]), .I5(lines[5]), .I6(lines[6]), .I7(lines[7]),
        .EI(EI), .ACK(ACK),
        .A0(a4_n[0]), .A1(a4_n[1]), .A2(a4_n[2]),
        .GS(gs4), .EO(eo4), .OVR(ovr4), .TMO(tmo4)
    );

    always #5 CLK = ~CLK;

    function automatic model_t model_reset();
        model_t r;
        r.pend = 8'h00; r.prev = 8'hFF; r.busy = 0; r.code = 0; r.timer = 0;
        r.a = 3'b111; r.gs = 1'b1; r.eo = 1'b1; r.ovr = 1'b0; r.tmo = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t m, input logic rst, input logic [7:0] l,
                                          input logic ei, input logic ack, input int ht,
                                          output bit presented);
        model_t n;
        int freed;
        int top;
        presented = 0;
        if (rst) return model_reset();
        n = m;
        n.prev = l;
        n.ovr = 1'b0;
        n.tmo = 1'b0;
        freed = -1;
        n.eo = !(!ei && m.pend == 8'h00 && !m.busy);
        if (!m.busy) begin
            if (m.pend != 8'h00) begin
                top = 7;
                while (!m.pend[top]) top--;
                n.busy = 1; n.code = top; n.timer = 0;
                n.a = ~3'(top); n.gs = 1'b0;
                presented = 1;
            end
        end else if (ack || (ht != 0 && m.timer == ht - 1)) begin
            freed = m.code;
            n.busy = 0; n.a = 3'b111; n.gs = 1'b1; n.tmo = !ack;
            n.pend[freed] = 1'b0;
        end else begin
            n.timer = m.timer + 1;
        end
        for (int k = 0; k < 8; k++) begin
            if (m.prev[k] && !l[k] && !ei) begin
                if (m.pend[k] && k != freed) n.ovr = 1'b1;
                n.pend[k] = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] l, input logic ei, input logic ack, input logic rst);
        @(negedge CLK);
        lines = l;
        EI = ei;
        ACK = ack;
        RST = rst;
    endtask

    task automatic wait_present(input string name, input logic [2:0] c);
        for (int i = 0; i < 8 && gs0 !== 1'b0; i++) apply_stimulus(lines, EI, 1'b0, 1'b0);
        check_output(name, {12'd0, a0_n, gs0}, {12'd0, ~c, 1'b0});
    endtask

    task automatic expect_code(input string name, input logic [2:0] c);
        check_output(name, {12'd0, a0_n, gs0}, {12'd0, ~c, 1'b0});
    endtask

    task automatic ack_and_gap(input string name);
        apply_stimulus(lines, EI, 1'b1, 1'b0);
        apply_stimulus(lines, EI, 1'b0, 1'b0);
        check_output(name, {15'd0, gs0}, 16'd1);
    endtask

    // Reference model advances on the same edge the DUTs sample their inputs.
    always @(posedge CLK) begin
        m0 = model_step(m0, RST, lines, EI, ACK, 0, p0);
        if (p0) q0.push_back(m0.code);
        m4 = model_step(m4, RST, lines, EI, ACK, 4, p4);
        if (p4) q4.push_back(m4.code);
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            check_output("cycle_dut0", {9'd0, a0_n, gs0, eo0, ovr0, tmo0},
                         {9'd0, m0.a, m0.gs, m0.eo, m0.ovr, m0.tmo});
            check_output("cycle_dut4", {9'd0, a4_n, gs4, eo4, ovr4, tmo4},
                         {9'd0, m4.a, m4.gs, m4.eo, m4.ovr, m4.tmo});
            if (gs0_prev === 1'b1 && gs0 === 1'b0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("[TB] FAIL sb_dut0_unexpected: got code A=%b, expected none at %0t", a0_n, $time);
                end else begin
                    check_output("sb_dut0_code", {13'd0, a0_n}, {13'd0, ~3'(q0.pop_front())});
                end
            end
            if (gs4_prev === 1'b1 && gs4 === 1'b0) begin
                if (q4.size() == 0) begin
                    tests++; fails++;
                    $display("[TB] FAIL sb_dut4_unexpected: got code A=%b, expected none at %0t", a4_n, $time);
                end else begin
                    check_output("sb_dut4_code", {13'd0, a4_n}, {13'd0, ~3'(q4.pop_front())});
                end
            end
        end
        gs0_prev = gs0;
        gs4_prev = gs4;
    end

    initial begin
        int ovr_count;
        int gs_low;
        int tmo_count;
        int held;
        logic [7:0] seq_ovr [5];

        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);
        mon_en = 1;
        check_output("reset_dut0", {9'd0, a0_n, gs0, eo0, ovr0, tmo0}, 16'b1111100);
        check_output("reset_dut4", {9'd0, a4_n, gs4, eo4, ovr4, tmo4}, 16'b1111100);

        // Single request on I5
        apply_stimulus(8'hDF, 1'b0, 1'b0, 1'b0);
        wait_present("single_code5", 3'd5);
        check_output("single_eo_high", {15'd0, eo0}, 16'd1);
        ack_and_gap("single_ack_gs_high");
        apply_stimulus(8'hDF, 1'b0, 1'b0, 1'b0);
        check_output("single_eo_low", {15'd0, eo0}, 16'd0);
        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        // I1, I3, I6 together
        apply_stimulus(8'hB5, 1'b0, 1'b0, 1'b0);
        wait_present("prio_code6", 3'd6);
        ack_and_gap("prio_gap1");
        apply_stimulus(lines, 1'b0, 1'b0, 1'b0);
        expect_code("prio_code3", 3'd3);
        ack_and_gap("prio_gap2");
        apply_stimulus(lines, 1'b0, 1'b0, 1'b0);
        expect_code("prio_code1", 3'd1);
        ack_and_gap("prio_gap3");
        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        // No pre-emption by I7, then I2 re-falls in its own ACK cycle
        apply_stimulus(8'hFB, 1'b0, 1'b0, 1'b0);
        wait_present("nopre_code2", 3'd2);
        repeat (4) apply_stimulus(8'h7B, 1'b0, 1'b0, 1'b0);
        expect_code("nopre_hold2", 3'd2);
        apply_stimulus(8'h7F, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'h7B, 1'b0, 1'b1, 1'b0);
        apply_stimulus(8'h7B, 1'b0, 1'b0, 1'b0);
        check_output("setwins_gap", {15'd0, gs0}, 16'd1);
        apply_stimulus(8'h7B, 1'b0, 1'b0, 1'b0);
        expect_code("nopre_code7", 3'd7);
        ack_and_gap("nopre_gap7");
        apply_stimulus(8'h7B, 1'b0, 1'b0, 1'b0);
        expect_code("setwins_code2", 3'd2);
        ack_and_gap("setwins_gap2");
        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        // I4 pulses twice before ACK
        seq_ovr = '{8'hEF, 8'hFF, 8'hEF, 8'hFF, 8'hFF};
        ovr_count = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(seq_ovr[i], 1'b0, 1'b0, 1'b0);
            ovr_count += int'(ovr0);
        end
        check_output("ovr_single_pulse", 16'(ovr_count), 16'd1);
        ack_and_gap("ovr_ack");
        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        // EI high blocks capture of I0
        repeat (4) apply_stimulus(8'hFE, 1'b1, 1'b0, 1'b0);
        check_output("ei_block_gs", {15'd0, gs0}, 16'd1);
        check_output("ei_block_eo", {15'd0, eo0}, 16'd1);
        apply_stimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (3) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);
        check_output("ei_not_deferred", {15'd0, gs0}, 16'd1);

        // Timeout on the 4-cycle instance; wait-forever instance keeps holding
        repeat (20) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);
        gs_low = 0;
        tmo_count = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(8'hF7, 1'b0, 1'b0, 1'b0);
            gs_low += int'(!gs4);
            tmo_count += int'(tmo4);
        end
        check_output("tmo_gs_low_cycles", 16'(gs_low), 16'd4);
        check_output("tmo_pulse_count", 16'(tmo_count), 16'd1);
        check_output("tmo_pend_cleared", {15'd0, gs4}, 16'd1);
        held = 0;
        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(8'hF7, 1'b0, 1'b0, 1'b0);
            held += int'(gs0 === 1'b0);
        end
        check_output("notmo_hold_1000", 16'(held), 16'd1000);
        expect_code("notmo_code3", 3'd3);
        ack_and_gap("notmo_ack");
        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        // Reset while code 5 is held and bits 1, 2 are pending
        apply_stimulus(8'hDF, 1'b0, 1'b0, 1'b0);
        wait_present("rst_code5", 3'd5);
        repeat (2) apply_stimulus(8'hD9, 1'b0, 1'b0, 1'b0);
        apply_stimulus(8'hDF, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'hDF, 1'b0, 1'b0, 1'b0);
        check_output("rst_mid_dut0", {10'd0, a0_n, gs0, ovr0, tmo0}, 16'b111100);
        check_output("rst_mid_dut4", {10'd0, a4_n, gs4, ovr4, tmo4}, 16'b111100);
        wait_present("rst_recapture5", 3'd5);
        ack_and_gap("rst_ack5");
        repeat (3) apply_stimulus(8'hDF, 1'b0, 1'b0, 1'b0);
        check_output("rst_pend_empty", {15'd0, gs0}, 16'd1);
        repeat (2) apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(lines ^ (8'($urandom) & 8'($urandom) & 8'($urandom)),
                           $urandom_range(0, 9) == 0,
                           $urandom_range(0, 2) == 0,
                           $urandom_range(0, 199) == 0);
        end
        repeat (30) apply_stimulus(8'hFF, 1'b0, 1'b1, 1'b0);
        apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);
        check_output("sb_dut0_drained", 16'(q0.size()), 16'd0);
        check_output("sb_dut4_drained", 16'(q4.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
